// File: rtl/scan_decoder_pkg.sv
// -----------------------------------------------------------------------------
// scan_decoder_pkg
// Shared types and constants for the scan decoder slice.
//   state_t      : controller state encoding (IDLE, DIRECT, SCAN)
//   MODE_DIRECT  : value of the mode input that selects direct addressing
//   MODE_SCAN    : value of the mode input that selects automatic scanning
// -----------------------------------------------------------------------------
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
// Purely combinational N-to-2**N one-hot decoder.
//   sel    : in  N       binary select
//   onehot : out 2**N    exactly one bit set, at position sel
// -----------------------------------------------------------------------------
module onehot_dec #(
  parameter int N = 3
) (
  input  logic [N-1:0]      sel,
  output logic [(2**N)-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
// Registered one-hot output driver with two operating modes:
//   DIRECT : a select word accepted over a valid/ready handshake is decoded
//            onto y one cycle later.
//   SCAN   : y walks through every position, holding each for dwell+1
//            cycles, and pulses wrap when it returns to position 0.
// Ports:
//   clk      : in  1         rising-edge clock
//   reset    : in  1         asynchronous, active-high reset
//   en       : in  1         0 blanks the output and forces IDLE
//   mode     : in  1         0 = DIRECT, 1 = SCAN
//   in_valid : in  1         select word valid
//   in_ready : out 1         select word can be accepted (DIRECT only)
//   a        : in  N         select word
//   dwell    : in  DWELL_W   extra cycles each SCAN position is held
//   y        : out 2**N      registered one-hot (or blank) output
//   idx      : out N         registered index currently driven on y
//   wrap     : out 1         one-cycle pulse when SCAN wraps back to 0
// -----------------------------------------------------------------------------
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int N          = 3,
  parameter int DWELL_W    = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       a,
  input  logic [DWELL_W-1:0] dwell,
  output logic [(2**N)-1:0]  y,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  localparam int L = 2**N;

  state_t             state;
  logic [L-1:0]       y_pat;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_lat;
  logic [N-1:0]       dec_sel;
  logic [L-1:0]       dec_out;
  logic               advance;

  // The single decoder is shared: it sees the accepted word in DIRECT, the
  // following position while scanning, and position 0 on any entry to SCAN.
  always_comb begin
    dec_sel = '0;
    if (state == ST_DIRECT && mode == MODE_DIRECT)
      dec_sel = a;
    else if (state == ST_SCAN && mode == MODE_SCAN)
      dec_sel = idx + N'(1);
  end

  onehot_dec #(.N(N)) u_dec (
    .sel    (dec_sel),
    .onehot (dec_out)
  );

  // dwell_lat holds the dwell value captured at the last reload, so a change
  // on the dwell input only affects the next position.
  assign advance  = (dwell_cnt == dwell_lat);
  assign in_ready = (state == ST_DIRECT);

  // Inversion sits after the register so y only ever changes on a clk edge.
  assign y = ACTIVE_LOW ? ~y_pat : y_pat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      y_pat     <= '0;
      idx       <= '0;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
      dwell_lat <= '0;
    end else if (!en) begin
      state     <= ST_IDLE;
      y_pat     <= '0;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mode == MODE_SCAN) begin
            state     <= ST_SCAN;
            idx       <= '0;
            y_pat     <= dec_out;
            dwell_cnt <= '0;
            dwell_lat <= dwell;
          end else begin
            state <= ST_DIRECT;
            y_pat <= '0;
          end
        end

        ST_DIRECT: begin
          if (mode == MODE_SCAN) begin
            state     <= ST_SCAN;
            idx       <= '0;
            y_pat     <= dec_out;
            dwell_cnt <= '0;
            dwell_lat <= dwell;
          end else if (in_valid) begin
            idx   <= a;
            y_pat <= dec_out;
          end
        end

        ST_SCAN: begin
          if (mode == MODE_DIRECT) begin
            // Output blanks until the first DIRECT transfer; the partial
            // dwell is thrown away so a later re-entry starts clean.
            state     <= ST_DIRECT;
            y_pat     <= '0;
            dwell_cnt <= '0;
          end else if (advance) begin
            idx       <= dec_sel;
            y_pat     <= dec_out;
            wrap      <= (idx == '1);
            dwell_cnt <= '0;
            dwell_lat <= dwell;
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          y_pat <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
// Self-checking bench for scan_decoder (N=3). Two instances share every
// input: one with active-high y, one with ACTIVE_LOW=1. Expected outputs are
// pushed to a scoreboard queue as each cycle's stimulus is driven and popped
// and compared once the DUT has produced that cycle's output.
// -----------------------------------------------------------------------------
module tb_scan_decoder;

  logic       clk;
  logic       reset;
  logic       en;
  logic       mode;
  logic       in_valid;
  logic [2:0] a;
  logic [7:0] dwell;

  logic       in_ready;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;

  logic       rdy_al;
  logic [7:0] y_al;
  logic [2:0] idx_al;
  logic       wrap_al;

  typedef struct {
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  scan_decoder #(.N(3), .DWELL_W(8), .ACTIVE_LOW(1'b0)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .dwell    (dwell),
    .y        (y),
    .idx      (idx),
    .wrap     (wrap)
  );

  scan_decoder #(.N(3), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut_al (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (rdy_al),
    .a        (a),
    .dwell    (dwell),
    .y        (y_al),
    .idx      (idx_al),
    .wrap     (wrap_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_exp(input logic [7:0] ey, input logic [2:0] ei,
                                   input logic ew, input logic er);
    exp_t t;
    t.y    = ey;
    t.idx  = ei;
    t.wrap = ew;
    t.rdy  = er;
    sb.push_back(t);
  endfunction

  function automatic logic [7:0] oh(input int p);
    logic [7:0] one;
    one = 8'd1;
    return one << p;
  endfunction

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; a = '0; dwell = '0;
    #2;
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({y, idx, wrap, in_ready, y_al, idx_al, wrap_al, rdy_al} !==
        {e.y, e.idx, e.wrap, e.rdy, ~e.y, e.idx, e.wrap, e.rdy}) begin
      failures++;
      $display("[TB] FAIL reset_async got y=%h idx=%0d wrap=%b rdy=%b y_al=%h want y=%h idx=%0d wrap=%b rdy=%b y_al=%h",
               y, idx, wrap, in_ready, y_al, e.y, e.idx, e.wrap, e.rdy, ~e.y);
    end
    for (int k = 0; k < 2; k++) begin
      en = 1'b1;
      push_exp(8'h00, 3'd0, 1'b0, 1'b0);
      cyc();
      e = sb.pop_front();
      checks++;
      if ({y, idx, wrap, in_ready, y_al, idx_al, wrap_al, rdy_al} !==
          {e.y, e.idx, e.wrap, e.rdy, ~e.y, e.idx, e.wrap, e.rdy}) begin
        failures++;
        $display("[TB] FAIL reset_hold[%0d] got y=%h idx=%0d wrap=%b rdy=%b y_al=%h want y=%h idx=%0d wrap=%b rdy=%b y_al=%h",
                 k, y, idx, wrap, in_ready, y_al, e.y, e.idx, e.wrap, e.rdy, ~e.y);
      end
    end
  endtask

  // Release reset straight into DIRECT with in_valid already high: the
  // transition cycle must not accept, then back-to-back transfers, then hold.
  task automatic test_direct();
    logic [7:0] ey [6];
    logic [2:0] ei [6];
    logic       v  [6];
    logic [2:0] av [6];
    ey = '{8'h00, 8'h40, 8'h20, 8'h20, 8'h20, 8'h20};
    ei = '{3'd0, 3'd6, 3'd5, 3'd5, 3'd5, 3'd5};
    v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    av = '{3'd6, 3'd6, 3'd5, 3'd2, 3'd2, 3'd2};
    reset = 1'b0; en = 1'b1; mode = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = v[k];
      a        = av[k];
      push_exp(ey[k], ei[k], 1'b0, 1'b1);
      cyc();
      e = sb.pop_front();
      checks++;
      if ({y, idx, wrap, in_ready, y_al, idx_al, wrap_al, rdy_al} !==
          {e.y, e.idx, e.wrap, e.rdy, ~e.y, e.idx, e.wrap, e.rdy}) begin
        failures++;
        $display("[TB] FAIL direct[%0d] got y=%h idx=%0d wrap=%b rdy=%b y_al=%h want y=%h idx=%0d wrap=%b rdy=%b y_al=%h",
                 k, y, idx, wrap, in_ready, y_al, e.y, e.idx, e.wrap, e.rdy, ~e.y);
      end
    end
  endtask

  // dwell=2: each position held 3 cycles, full period 24, wrap on return to 0.
  task automatic test_scan_dwell2();
    int p;
    mode = 1'b1; dwell = 8'd2; in_valid = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      p = ((k - 1) / 3) % 8;
      push_exp(oh(p), 3'(p), (k > 1) && ((k - 1) % 24 == 0), 1'b0);
      cyc();
      e = sb.pop_front();
      checks++;
      if ({y, idx, wrap, in_ready, y_al, idx_al, wrap_al, rdy_al} !==
          {e.y, e.idx, e.wrap, e.rdy, ~e.y, e.idx, e.wrap, e.rdy}) begin
        failures++;
        $display("[TB] FAIL scan_dwell2[%0d] got y=%h idx=%0d wrap=%b rdy=%b want y=%h idx=%0d wrap=%b rdy=%b",
                 k, y, idx, wrap, in_ready, e.y, e.idx, e.wrap, e.rdy);
      end
    end
  endtask

  // en=0 while scanning at idx=1: output blanks, idx is held.
  task automatic test_enable_blank();
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      push_exp(8'h00, 3'd1, 1'b0, 1'b0);
      cyc();
      e = sb.pop_front();
      checks++;
      if ({y, idx, wrap, in_ready, y_al, idx_al, wrap_al, rdy_al} !==
          {e.y, e.idx, e.wrap, e.rdy, ~e.y, e.idx, e.wrap, e.rdy}) begin
        failures++;
        $display("[TB] FAIL en_blank[%0d] got y=%h idx=%0d wrap=%b rdy=%b want y=%h idx=%0d wrap=%b rdy=%b",
                 k, y, idx, wrap, in_ready, e.y, e.idx, e.wrap, e.rdy);
      end
    end
  endtask

  // dwell=0 with a=3/in_valid=1 applied throughout: advances every cycle and
  // the select word never appears.
  task automatic test_scan_dwell0();
    int p;
    en = 1'b1; mode = 1'b1; dwell = 8'd0; in_valid = 1'b1; a = 3'd3;
    for (int k = 1; k <= 17; k++) begin
      p = (k - 1) % 8;
      push_exp(oh(p), 3'(p), (k > 1) && (p == 0), 1'b0);
      cyc();
      e = sb.pop_front();
      checks++;
      if ({y, idx, wrap, in_ready, y_al, idx_al, wrap_al, rdy_al} !==
          {e.y, e.idx, e.wrap, e.rdy, ~e.y, e.idx, e.wrap, e.rdy}) begin
        failures++;
        $display("[TB] FAIL scan_dwell0[%0d] got y=%h idx=%0d wrap=%b rdy=%b want y=%h idx=%0d wrap=%b rdy=%b",
                 k, y, idx, wrap, in_ready, e.y, e.idx, e.wrap, e.rdy);
      end
    end
  endtask

  // Leave SCAN at idx=4 mid-dwell, sit in DIRECT blank, then re-enter SCAN
  // which must restart from idx 0 with a fresh dwell count.
  task automatic test_scan_to_direct();
    int p;
    in_valid = 1'b0;
    for (int k = 0; k < 23; k++) begin
      if (k == 0) begin
        mode = 1'b0;
        push_exp(8'h00, 3'd0, 1'b0, 1'b1);
      end else if (k <= 18) begin
        mode = 1'b1; dwell = 8'd3;
        p = (k - 1) / 4;
        push_exp(oh(p), 3'(p), 1'b0, 1'b0);
      end else if (k <= 20) begin
        mode = 1'b0;
        push_exp(8'h00, 3'd4, 1'b0, 1'b1);
      end else begin
        mode = 1'b1;
        push_exp(8'h01, 3'd0, 1'b0, 1'b0);
      end
      cyc();
      e = sb.pop_front();
      checks++;
      if ({y, idx, wrap, in_ready, y_al, idx_al, wrap_al, rdy_al} !==
          {e.y, e.idx, e.wrap, e.rdy, ~e.y, e.idx, e.wrap, e.rdy}) begin
        failures++;
        $display("[TB] FAIL scan_to_direct[%0d] got y=%h idx=%0d wrap=%b rdy=%b want y=%h idx=%0d wrap=%b rdy=%b",
                 k, y, idx, wrap, in_ready, e.y, e.idx, e.wrap, e.rdy);
      end
    end
  endtask

  // Reset dropped in between edges while scanning at idx=1 must clear the
  // outputs immediately; after release scanning starts over with no residue.
  task automatic test_async_reset();
    int p;
    for (int k = 3; k <= 5; k++) begin
      p = (k - 1) / 4;
      push_exp(oh(p), 3'(p), 1'b0, 1'b0);
      cyc();
      e = sb.pop_front();
      checks++;
      if ({y, idx, wrap, in_ready} !== {e.y, e.idx, e.wrap, e.rdy}) begin
        failures++;
        $display("[TB] FAIL pre_reset[%0d] got y=%h idx=%0d wrap=%b rdy=%b want y=%h idx=%0d wrap=%b rdy=%b",
                 k, y, idx, wrap, in_ready, e.y, e.idx, e.wrap, e.rdy);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({y, idx, wrap, in_ready, y_al, idx_al, wrap_al, rdy_al} !==
        {e.y, e.idx, e.wrap, e.rdy, ~e.y, e.idx, e.wrap, e.rdy}) begin
      failures++;
      $display("[TB] FAIL reset_mid_cycle got y=%h idx=%0d wrap=%b rdy=%b y_al=%h want y=%h idx=%0d wrap=%b rdy=%b y_al=%h",
               y, idx, wrap, in_ready, y_al, e.y, e.idx, e.wrap, e.rdy, ~e.y);
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        push_exp(8'h00, 3'd0, 1'b0, 1'b0);
      end else begin
        reset = 1'b0; en = 1'b1; mode = 1'b1; dwell = 8'd0;
        push_exp(oh(k - 1), 3'(k - 1), 1'b0, 1'b0);
      end
      cyc();
      e = sb.pop_front();
      checks++;
      if ({y, idx, wrap, in_ready, y_al, idx_al, wrap_al, rdy_al} !==
          {e.y, e.idx, e.wrap, e.rdy, ~e.y, e.idx, e.wrap, e.rdy}) begin
        failures++;
        $display("[TB] FAIL post_reset[%0d] got y=%h idx=%0d wrap=%b rdy=%b want y=%h idx=%0d wrap=%b rdy=%b",
                 k, y, idx, wrap, in_ready, e.y, e.idx, e.wrap, e.rdy);
      end
    end
  endtask

  // DIRECT transfer of a=0: active-low copy must read 8'hFE.
  task automatic test_active_low();
    logic [7:0] ey [3];
    logic [2:0] ei [3];
    logic       v  [3];
    ey = '{8'h00, 8'h01, 8'h01};
    ei = '{3'd1, 3'd0, 3'd0};
    v  = '{1'b0, 1'b1, 1'b0};
    mode = 1'b0; a = 3'd0;
    for (int k = 0; k < 3; k++) begin
      in_valid = v[k];
      push_exp(ey[k], ei[k], 1'b0, 1'b1);
      cyc();
      e = sb.pop_front();
      checks++;
      if ({y, idx, wrap, in_ready, y_al, idx_al, wrap_al, rdy_al} !==
          {e.y, e.idx, e.wrap, e.rdy, ~e.y, e.idx, e.wrap, e.rdy}) begin
        failures++;
        $display("[TB] FAIL active_low[%0d] got y=%h y_al=%h idx=%0d rdy=%b want y=%h y_al=%h idx=%0d rdy=%b",
                 k, y, y_al, idx, in_ready, e.y, ~e.y, e.idx, e.rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_dwell2();
    test_enable_blank();
    test_scan_dwell0();
    test_scan_to_direct();
    test_async_reset();
    test_active_low();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameters SHALL be:
- N, default 3, select width; output width is 2**N.
- DWELL_W, default 8, width of the dwell count.
- ACTIVE_LOW, default 0; when 1, y is the bitwise inverse of the one-hot/blank pattern.

REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  enable; 0 blanks the output and forces IDLE
- mode  in  1  0 = DIRECT, 1 = SCAN
- in_valid  in  1  select word valid
- in_ready  out  1  select word can be accepted
- a  in  N  select word
- dwell  in  DWELL_W  extra cycles each SCAN position is held
- y  out  2**N  registered one-hot output
- idx  out  N  registered index currently driven on y
- wrap  out  1  one-cycle pulse on SCAN wrap-around

REQ-003 The block SHALL use one clock (clk); reset SHALL be asynchronous and active-high.

Function
REQ-004 The state machine SHALL have states IDLE, DIRECT and SCAN.
REQ-005 From any state, en=0 SHALL select IDLE at the next edge.
REQ-006 From IDLE with en=1, the next state SHALL be DIRECT when mode=0 and SCAN when mode=1.
REQ-007 A mode change while en=1 SHALL move DIRECT to SCAN or SCAN to DIRECT at the next edge.
REQ-008 In IDLE, y SHALL be all-inactive, idx SHALL hold its value, in_ready=0 and wrap=0.
REQ-009 in_ready SHALL be 1 only in DIRECT; it is combinational from the state, not from in_valid.
REQ-010 In DIRECT, the transfer in_valid and in_ready SHALL register a into idx and set y to the one-hot of a at the next edge (latency 1).
REQ-011 In DIRECT with no transfer, y and idx SHALL hold their values.
REQ-012 On entry to DIRECT, y SHALL be all-inactive until the first transfer; an in_valid in the IDLE-to-DIRECT transition cycle SHALL NOT be accepted.
REQ-013 On entry to SCAN, the next edge SHALL set idx=0 and y=one-hot(0), and SHALL clear the dwell counter.
REQ-014 In SCAN, each position SHALL be held for dwell+1 cycles. dwell is sampled when the counter reloads, so a change applies from the next position. dwell=0 advances every cycle.
REQ-015 In SCAN, idx SHALL increment modulo 2**N. When idx advances from 2**N-1 to 0, wrap SHALL be 1 for exactly the one cycle in which idx=0 is first presented.
REQ-016 In SCAN, a and in_valid SHALL be ignored.
REQ-017 Leaving SCAN mid-dwell SHALL discard the dwell count; re-entering SCAN restarts at idx 0.
REQ-018 y SHALL always be either exactly one active bit or all-inactive, and never change other than on a clk edge.
REQ-019 When ACTIVE_LOW=1, the active level of y SHALL be 0; idx, wrap and in_ready are unaffected.

Reset
REQ-020 While reset=1, the outputs SHALL be held immediately, independent of clk: state=IDLE, y all-inactive (0, or all-ones when ACTIVE_LOW=1), idx=0, wrap=0, in_ready=0, dwell counter=0.
REQ-021 Reset asserted mid-dwell or mid-transfer SHALL abort the operation with no pending effect after release.
REQ-022 The first state change after reset release SHALL occur on the first clk edge with reset=0.

Structure
REQ-023 Package scan_decoder_pkg SHALL hold the state enum typedef and the mode encodings MODE_DIRECT=0 and MODE_SCAN=1.
REQ-024 A combinational sub-module onehot_dec SHALL provide the N-to-2**N one-hot function (parameter N) and be instantiated once. The active-level inversion SHALL be applied in scan_decoder after the output register.

Verification
REQ-025 N=3, DIRECT, transfer a=5 -> y=8'b0010_0000 and idx=5 one cycle later; y holds while in_valid=0.
REQ-026 N=3, SCAN, dwell=2 -> idx sequence 0,0,0,1,1,1,...,7,7,7,0. wrap is high only on the first cycle of the returning 0. Check 24 cycles per period.
REQ-027 SCAN, dwell=0 -> idx increments every cycle; wrap every 8 cycles; in_valid=1 with a=3 has no effect and in_ready=0.
REQ-028 SCAN at idx=4 mid-dwell, mode toggled to 0 -> y=0 in DIRECT until a transfer. Toggle mode back -> restarts at idx=0.
REQ-029 en=0 during SCAN -> y=0 next edge and idx held. Reset asserted between edges -> y=0 and idx=0 without a clk edge.
REQ-030 ACTIVE_LOW=1, DIRECT, a=0 -> y=8'b1111_1110; during reset y=8'hFF.
